// File: rtl/fc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fc_ctrl_pkg                                                      |
// | Brief   : Shared types, default sizes and address-width helper for the     |
// |           Fully_Connected sequencer. Optional build macro: FC_BIAS_EN.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } fc_state_t;

    localparam int DEFAULT_IFM_DEPTH    = 120;
    localparam int DEFAULT_NUMBER_OF_WM = 84;
    localparam int DEFAULT_RD_LAT       = 1;
    localparam int DEFAULT_ACC_LAT      = 2;

`ifdef FC_BIAS_EN
    localparam int FC_BIAS_WORDS = 1;
`else
    localparam int FC_BIAS_WORDS = 0;
`endif

    // The bias word sits at address IFM_DEPTH, right after the weights.
    function automatic int fc_wm_addr_width(input int depth);
        return $clog2(depth + FC_BIAS_WORDS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_layer_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fc_layer_sequencer_if                                            |
// | Brief   : Control/address bundle between layer controller and sequencer.   |
// |           Optional build macro: FC_BIAS_EN (adds bias_sel).                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface fc_layer_sequencer_if
    import fc_ctrl_pkg::*;
#(
    parameter int ADDRESS_BUS     = 19,
    parameter int ADDRESS_SIZE_WM = fc_wm_addr_width(DEFAULT_IFM_DEPTH)
);
    logic                       start;
    logic                       hold;
    logic [ADDRESS_BUS-1:0]     ifm_base;
    logic [ADDRESS_BUS-1:0]     ifm_addr;
    logic [ADDRESS_SIZE_WM-1:0] wm_addr;
    logic                       rd_en;
    logic                       acc_clr;
    logic                       acc_en;
    logic                       busy;
    logic                       done;
`ifdef FC_BIAS_EN
    logic                       bias_sel;
`endif

    modport master (
        output start, hold, ifm_base,
        input  ifm_addr, wm_addr, rd_en, acc_clr, acc_en, busy, done
`ifdef FC_BIAS_EN
        , input bias_sel
`endif
    );

    modport slave (
        input  start, hold, ifm_base,
        output ifm_addr, wm_addr, rd_en, acc_clr, acc_en, busy, done
`ifdef FC_BIAS_EN
        , output bias_sel
`endif
    );

endinterface
`default_nettype wire

// File: rtl/fc_valid_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fc_valid_delay                                                   |
// | Brief   : DEPTH-stage valid shift register with occupancy flags.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fc_valid_delay #(
    parameter int DEPTH = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic valid_in,
    output logic      valid_out,
    output logic      empty,
    output logic      empty_next
);
    logic [DEPTH-1:0] r_line;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_line <= '0;
                else        r_line <= valid_in;
            end
            assign empty_next = ~valid_in;
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_line <= '0;
                else        r_line <= {r_line[DEPTH-2:0], valid_in};
            end
            // Only the output stage may still be set: the line is empty after this shift.
            assign empty_next = ~valid_in & ~(|r_line[DEPTH-2:0]);
        end
    endgenerate

    assign valid_out = r_line[DEPTH-1];
    assign empty     = ~(|r_line);

endmodule
`default_nettype wire

// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fc_layer_sequencer                                               |
// | Brief   : Walks IFM elements, issues IFM/weight reads and aligns accumulator|
// |           strobes. Optional build macro: FC_BIAS_EN (extra bias read).     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fc_layer_sequencer
    import fc_ctrl_pkg::*;
#(
    parameter int IFM_DEPTH       = DEFAULT_IFM_DEPTH,
    parameter int NUMBER_OF_WM    = DEFAULT_NUMBER_OF_WM,
    parameter int ADDRESS_SIZE_WM = fc_wm_addr_width(IFM_DEPTH),
    parameter int ADDRESS_BUS     = 19,
    parameter int RD_LAT          = DEFAULT_RD_LAT,
    parameter int ACC_LAT         = DEFAULT_ACC_LAT
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    fc_layer_sequencer_if.slave   bus
);
    localparam logic [ADDRESS_SIZE_WM-1:0] c_last_idx  = ADDRESS_SIZE_WM'(IFM_DEPTH - 1);
    localparam logic [ADDRESS_SIZE_WM-1:0] c_final_idx = ADDRESS_SIZE_WM'(IFM_DEPTH - 1 + FC_BIAS_WORDS);
    localparam logic [2:0]                 c_acc_lat   = 3'(ACC_LAT);

    fc_state_t                  r_state, w_state_nxt;
    logic [ADDRESS_SIZE_WM-1:0] r_idx;
    logic [ADDRESS_BUS-1:0]     r_ifm_addr;
    logic [2:0]                 r_drain_cnt, w_drain_cnt_nxt;
    logic                       w_issue;
    logic                       w_acc_en;
    logic                       w_dly_empty;
    logic                       w_dly_empty_next;

    assign w_issue = (r_state == ISSUE) && !bus.hold;

    fc_valid_delay #(.DEPTH(RD_LAT)) u_valid_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (w_issue),
        .valid_out  (w_acc_en),
        .empty      (w_dly_empty),
        .empty_next (w_dly_empty_next)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            IDLE:  if (bus.start) w_state_nxt = CLEAR;
            CLEAR: w_state_nxt = ISSUE;
            ISSUE: begin
                if (w_issue && (r_idx == c_final_idx)) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                // ACC_LAT counts from the first cycle with no read left in flight.
                if (w_dly_empty_next) begin
                    if (r_drain_cnt == c_acc_lat) w_state_nxt = DONE;
                    else                          w_drain_cnt_nxt = r_drain_cnt + 3'd1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_ifm_addr <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_idx      <= '0;
            r_ifm_addr <= bus.ifm_base;
        end else if (w_issue && (r_idx != c_final_idx)) begin
            r_idx <= r_idx + ADDRESS_SIZE_WM'(1);
            // The bias read reuses the last IFM address.
            if (r_idx != c_last_idx) r_ifm_addr <= r_ifm_addr + ADDRESS_BUS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (NUMBER_OF_WM > 0 && RD_LAT >= 1 && RD_LAT <= 4 && ACC_LAT >= 0 && ACC_LAT <= 7);
            assert (r_idx <= c_final_idx);
            assert ((r_state != DONE) || w_dly_empty);
        end
    end

    assign bus.ifm_addr = r_ifm_addr;
    assign bus.wm_addr  = r_idx;
    assign bus.rd_en    = w_issue;
    assign bus.acc_clr  = (r_state == CLEAR);
    assign bus.acc_en   = w_acc_en;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
`ifdef FC_BIAS_EN
    assign bus.bias_sel = w_issue && (r_idx == c_final_idx);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fc_layer_sequencer                                            |
// | Brief   : Directed bench; two instances (RD_LAT=1/ACC_LAT=2, RD_LAT=3/0).  |
// |           Honours FC_BIAS_EN.                                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fc_layer_sequencer;
    import fc_ctrl_pkg::*;

    localparam int N  = 120;
    localparam int AW = fc_wm_addr_width(N);
    localparam int B  = FC_BIAS_WORDS;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        hold     = 1'b0;
    logic [18:0] ifm_base = '0;
    int          total    = 0;
    int          bad      = 0;

    always #5 clk = ~clk;

    fc_layer_sequencer_if #(.ADDRESS_BUS(19), .ADDRESS_SIZE_WM(AW)) bus1 ();
    fc_layer_sequencer_if #(.ADDRESS_BUS(19), .ADDRESS_SIZE_WM(AW)) bus2 ();

    assign bus1.start    = start;
    assign bus1.hold     = hold;
    assign bus1.ifm_base = ifm_base;
    assign bus2.start    = start;
    assign bus2.hold     = hold;
    assign bus2.ifm_base = ifm_base;

    fc_layer_sequencer #(
        .IFM_DEPTH(N), .NUMBER_OF_WM(84), .ADDRESS_SIZE_WM(AW),
        .ADDRESS_BUS(19), .RD_LAT(1), .ACC_LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    fc_layer_sequencer #(
        .IFM_DEPTH(N), .NUMBER_OF_WM(84), .ADDRESS_SIZE_WM(AW),
        .ADDRESS_BUS(19), .RD_LAT(3), .ACC_LAT(0)
    ) dut_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ifm_addr"}, 32'(bus1.ifm_addr), 0);
        chk({tag, "_wm_addr"},  32'(bus1.wm_addr),  0);
        chk({tag, "_rd_en"},    32'(bus1.rd_en),    0);
        chk({tag, "_acc_clr"},  32'(bus1.acc_clr),  0);
        chk({tag, "_acc_en"},   32'(bus1.acc_en),   0);
        chk({tag, "_busy"},     32'(bus1.busy),     0);
        chk({tag, "_done"},     32'(bus1.done),     0);
        chk({tag, "_busy2"},    32'(bus2.busy),     0);
        chk({tag, "_acc_en2"},  32'(bus2.acc_en),   0);
    endtask

    // Cycle c is the interval after clock edge c; start is sampled at edge 0.
    task automatic run_pass(input logic [18:0] base, input int hold_first, input int hold_len,
                            input bit glitch, input int rst_cyc, input int exp_done);
        int rd1, acc1, acc2, clr1, first_rd1, first_acc1, first_acc2, done1, done2;
        rd1 = 0; acc1 = 0; acc2 = 0; clr1 = 0;
        first_rd1 = -1; first_acc1 = -1; first_acc2 = -1; done1 = -1; done2 = -1;
        @(negedge clk);
        start    = 1'b1;
        ifm_base = base;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            hold  = (c >= hold_first) && (c < hold_first + hold_len);
            start = glitch && (c == 60);
            #1;
            if (c == rst_cyc) begin
                #1 rst_n = 1'b0;
                #1 chk_all_zero("async_rst");
                @(negedge clk) rst_n = 1'b1;
                @(posedge clk); #1;
                chk("busy_after_rst", 32'(bus1.busy), 0);
                return;
            end
            if (c == 1) chk("busy_cycle1", 32'(bus1.busy), 1);
            if (bus1.acc_clr) begin
                clr1++;
                chk("acc_clr_cycle", 32'(c), 1);
            end
            if (hold) chk("rd_en_in_hold", 32'(bus1.rd_en), 0);
            if (bus1.rd_en) begin
                if (first_rd1 < 0) first_rd1 = c;
                if (rd1 < N) begin
                    chk("wm_addr", 32'(bus1.wm_addr), 32'(rd1));
                    chk("ifm_addr", 32'(bus1.ifm_addr), 32'(base) + 32'(rd1));
`ifdef FC_BIAS_EN
                    chk("bias_sel_low", 32'(bus1.bias_sel), 0);
                end else begin
                    chk("bias_sel_high", 32'(bus1.bias_sel), 1);
                    chk("bias_wm_addr", 32'(bus1.wm_addr), N);
`endif
                end
                rd1++;
            end
            if (bus1.acc_en) begin
                if (first_acc1 < 0) first_acc1 = c;
                acc1++;
            end
            if (bus2.acc_en) begin
                if (first_acc2 < 0) first_acc2 = c;
                acc2++;
            end
            if (bus1.done && done1 < 0) begin
                done1 = c;
                chk("busy_at_done", 32'(bus1.busy), 1);
                if (glitch) start = 1'b1;
            end
            if (bus2.done && done2 < 0) done2 = c;
            if (done1 >= 0 && done2 >= 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        hold  = 1'b0;
        chk("busy_after_done", 32'(bus1.busy), 0);
        chk("done_one_cycle", 32'(bus1.done), 0);
        chk("busy2_after_done", 32'(bus2.busy), 0);
        chk("acc_clr_count", 32'(clr1), 1);
        chk("first_rd_en", 32'(first_rd1), 2);
        chk("rd_en_count", 32'(rd1), N + B);
        chk("acc_en_count", 32'(acc1), N + B);
        chk("first_acc_en", 32'(first_acc1), 3);
        chk("done_cycle", 32'(done1), 32'(exp_done));
        chk("acc_en_count_lat3", 32'(acc2), N + B);
        chk("first_acc_en_lat3", 32'(first_acc2), 5);
        chk("done_cycle_lat3", 32'(done2), 32'(exp_done));
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(bus1.busy), 0);

        // Plain pass: done at 120+2+1+2 = 125 (lat3 instance: 120+2+3+0 = 125).
        run_pass(19'h00100, 0, 0, 1'b0, 0, 125 + B);

        // Hold for 5 cycles while wm_addr = 50 (cycles 52..56): done at 130.
        run_pass(19'h7FF00, 52, 5, 1'b0, 0, 130 + B);

        // start pulsed in ISSUE and again at done must both be ignored.
        run_pass(19'h12345, 0, 0, 1'b1, 0, 125 + B);

        // Immediately following pass (start one cycle after DONE) is clean.
        run_pass(19'h00000, 0, 0, 1'b0, 0, 125 + B);

        // Asynchronous reset mid-pass, then a full pass afterwards.
        run_pass(19'h00200, 0, 0, 1'b0, 60, 125 + B);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_rst", 32'(bus1.busy), 0);
        run_pass(19'h00100, 0, 0, 1'b0, 0, 125 + B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Control sequencer for the Fully_Connected multiplier bank (one IFM element × NUMBER_OF_WM weights per cycle). It walks the IFM_DEPTH input elements, drives the IFM and weight-memory read addresses, and aligns accumulator clear and enable strobes with memory read latency. It raises `done` when all NUMBER_OF_WM accumulators hold final dot products. It sits between the layer-level top controller and the multiplier/accumulator datapath.

## Interface
- `IFM_DEPTH`, 120: number of input elements per inference.
- `NUMBER_OF_WM`, 84: number of weight memories / outputs; informational, used only for assertions.
- `ADDRESS_SIZE_WM`, `$clog2(IFM_DEPTH)`: weight-memory address width.
- `ADDRESS_BUS`, 19: IFM address width.
- `RD_LAT`, 1: cycles from `rd_en` to valid `Data_in`/`Data_Weight_*`; range 1..4.
- `ACC_LAT`, 2: cycles from last `acc_en` until accumulator results are stable; range 0..7.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin one layer pass; sampled only in IDLE.
- `hold`, in, 1: freeze address issue (upstream not ready).
- `ifm_base`, in, ADDRESS_BUS: IFM base address, latched on accepted `start`.
- `ifm_addr`, out, ADDRESS_BUS: `ifm_base + idx`.
- `wm_addr`, out, ADDRESS_SIZE_WM: `idx`, shared by all weight memories.
- `rd_en`, out, 1: memory read strobe.
- `acc_clr`, out, 1: clear all accumulators.
- `acc_en`, out, 1: accumulate the current products.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 → CLEAR, latch `ifm_base`, `idx`:=0. `start` is ignored in all other states.
- CLEAR: `acc_clr`=1 for exactly one cycle → ISSUE.
- ISSUE: when `hold`=0: `rd_en`=1 and `idx` increments. When `hold`=1: `rd_en`=0 and `idx` holds.
  - The issue at `idx`=IFM_DEPTH-1 with `hold`=0 → DRAIN.
  - `idx` never wraps; addresses stay within 0..IFM_DEPTH-1.
- `acc_en` is `rd_en` delayed by exactly RD_LAT cycles through a valid delay line. The delay line keeps shifting during `hold`, so bubbles propagate.
- DRAIN: wait until the delay line is empty, then ACC_LAT further cycles → DONE.
- DONE: `done`=1 for one cycle → IDLE. `busy` falls in the cycle after DONE.
- `ifm_addr` and `wm_addr` are registered. Outside ISSUE they hold their last value.
- `rst_n` low at any time: immediately go to IDLE, clear the delay line, and drive all outputs to 0. There is no partial-result recovery.

## Timing
- Reset values: `ifm_addr`=0, `wm_addr`=0, `rd_en`=0, `acc_clr`=0, `acc_en`=0, `busy`=0, `done`=0.
- Cycle numbering, with `start` sampled at edge 0 and no `hold`:
  - `acc_clr` in cycle 1.
  - `rd_en` in cycles 2..IFM_DEPTH+1.
  - `acc_en` in cycles 2+RD_LAT..IFM_DEPTH+1+RD_LAT.
  - `done` in cycle IFM_DEPTH+2+RD_LAT+ACC_LAT (defaults: 125).
- Each `hold` cycle during ISSUE adds exactly one cycle to `done` latency. `hold` outside ISSUE has no effect.
- `start` coincident with `done`: ignored, because the FSM is not in IDLE. `start` is accepted in the following cycle at the earliest.
- Throughput: one element per cycle; back-to-back passes are separated by 2 idle cycles minimum (DONE, IDLE).

## Configuration
- `FC_BIAS_EN` defined:
  - Adds output `bias_sel` (1 bit).
  - After the last element, ISSUE performs one extra issue with `rd_en`=1, `bias_sel`=1 and `wm_addr`=IFM_DEPTH, which reads the bias word stored after the weights. ADDRESS_SIZE_WM is then computed as `$clog2(IFM_DEPTH+1)`.
  - Default `done` latency becomes 126.
- `FC_BIAS_EN` undefined: no `bias_sel` port; exactly IFM_DEPTH issues.

## Structure
- Package `fc_ctrl_pkg` holds:
  - state enum `fc_state_t` (IDLE, CLEAR, ISSUE, DRAIN, DONE);
  - default-parameter localparams (IFM_DEPTH, NUMBER_OF_WM, RD_LAT, ACC_LAT);
  - the width helper for ADDRESS_SIZE_WM.
- Sub-module `fc_valid_delay`: parameterised RD_LAT-deep valid shift register with async reset and an `empty` output; used for `acc_en` generation and the DRAIN condition.

## Test plan
- Reset, then `start` with `ifm_base`=0x100, no `hold`:
  - `acc_clr` in cycle 1;
  - 120 `rd_en` pulses with `ifm_addr` 0x100..0x177 and `wm_addr` 0..119;
  - 120 `acc_en` pulses offset by 1;
  - `done` in cycle 125.
- `hold`=1 for 5 cycles at `idx`=50 → `wm_addr` stalls at 50, `acc_en` shows a 5-cycle bubble, `done` in cycle 130, still exactly 120 `acc_en` pulses.
- `start` pulsed during ISSUE and at DONE → ignored; the next `start`, one cycle after DONE, begins a clean pass with `acc_clr`.
- `rst_n` asserted at cycle 60 → all outputs 0 asynchronously. After release, `busy`=0 and the next `start` gives the full 125-cycle pass.
- RD_LAT=3, ACC_LAT=0 → first `acc_en` in cycle 5, `done` in cycle 125.
- With `FC_BIAS_EN` defined → 121 `rd_en` pulses, the last one with `bias_sel`=1 and `wm_addr`=120, `done` in cycle 126.
